// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU request/response handshake and the
// byte-wide memory port. slave = the unit's view, master = environment view.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    // CPU side
    logic                  req;
    logic                  ready;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [15:0]           write_data;
    logic [15:0]           read_data;
    logic                  done;
    logic                  error;
    // Memory side
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_write_byte;
    logic                  mem_write;
    logic                  mem_read;
    logic [7:0]            mem_read_byte;

    modport slave (
        input  req, write, address, write_data, mem_read_byte,
        output ready, read_data, done, error,
        output mem_address, mem_write_byte, mem_write, mem_read
    );

    modport master (
        output req, write, address, write_data, mem_read_byte,
        input  ready, read_data, done, error,
        input  mem_address, mem_write_byte, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: splits 16-bit big-endian loads/stores into two byte
// accesses (high byte at A, low byte at A+1) and pulses done on completion.
// Ports: i_clock, i_reset (sync, active-high), bus (mem_access_unit_if.slave).
// Optional: define ALIGN_CHECK_EN to reject odd addresses with done+error.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [7:0]            r_hi;
    logic [15:0]           r_rdata;
    logic                  r_done;
    logic                  r_error;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_misalign;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [7:0]            w_wbyte;
    logic                  w_we;
    logic                  w_re;

    assign w_ready  = (r_state == S_IDLE) && !i_reset;
    assign w_accept = bus.req && w_ready;

`ifdef ALIGN_CHECK_EN
    // Odd request completes immediately with no memory cycle.
    assign w_misalign = w_accept && bus.address[0];
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_mem_addr = '0;
        w_wbyte    = '0;
        w_we       = 1'b0;
        w_re       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misalign) begin
                    w_next = S_HI;
                end
            end
            S_HI: begin
                w_mem_addr = r_addr;
                if (r_write) begin
                    w_wbyte = r_wdata[15:8];
                    w_we    = 1'b1;
                end else begin
                    w_re    = 1'b1;
                end
                w_next = S_LO;
            end
            S_LO: begin
                // Wraps modulo 2^ADDR_WIDTH by width truncation.
                w_mem_addr = r_addr + ADDR_WIDTH'(1);
                if (r_write) begin
                    w_wbyte = r_wdata[7:0];
                    w_we    = 1'b1;
                end else begin
                    w_re    = 1'b1;
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_LO) || w_misalign;
            r_error <= w_misalign;
            if (w_accept) begin
                r_write <= bus.write;
                r_addr  <= bus.address;
                r_wdata <= bus.write_data;
            end
            if (r_state == S_HI && !r_write) begin
                r_hi <= bus.mem_read_byte;
            end
            // Only a whole word is ever published.
            if (r_state == S_LO && !r_write) begin
                r_rdata <= {r_hi, bus.mem_read_byte};
            end
        end
    end

    assign bus.ready          = w_ready;
    assign bus.read_data      = r_rdata;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.mem_address    = w_mem_addr;
    assign bus.mem_write_byte = w_wbyte;
    assign bus.mem_write      = w_we;
    assign bus.mem_read       = w_re;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte memory model, directed vector table,
// back-to-back, reset-in-HI and wrap/alignment sequences.
module tb_mem_access_unit;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(AW)) mif ();

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (mif)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (mif.mem_write) mem[mif.mem_address] = mif.mem_write_byte;
    end

    assign mif.mem_read_byte = mem[mif.mem_address];

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] last_rd;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd,
                       input string nm);
        logic [15:0] a1;
        a1 = a + 16'd1;
        mif.req        = 1'b1;
        mif.write      = wr;
        mif.address    = a;
        mif.write_data = d;
        @(negedge clk);
        chk({nm, " ready"}, 32'(mif.ready), 32'd1);
        tick();
        mif.req        = 1'b0;
        mif.write      = ~wr;
        mif.address    = ~a;
        mif.write_data = ~d;
        @(negedge clk);
        chk({nm, " hi addr"}, 32'(mif.mem_address), 32'(a));
        chk({nm, " hi we"}, 32'(mif.mem_write), 32'(wr));
        chk({nm, " hi re"}, 32'(mif.mem_read), 32'(!wr));
        if (wr) chk({nm, " hi byte"}, 32'(mif.mem_write_byte), 32'(d[15:8]));
        chk({nm, " hi done"}, 32'(mif.done), 32'd0);
        chk({nm, " hi ready"}, 32'(mif.ready), 32'd0);
        chk({nm, " hi rdata"}, 32'(mif.read_data), 32'(last_rd));
        tick();
        @(negedge clk);
        chk({nm, " lo addr"}, 32'(mif.mem_address), 32'(a1));
        chk({nm, " lo we"}, 32'(mif.mem_write), 32'(wr));
        chk({nm, " lo re"}, 32'(mif.mem_read), 32'(!wr));
        if (wr) chk({nm, " lo byte"}, 32'(mif.mem_write_byte), 32'(d[7:0]));
        chk({nm, " lo done"}, 32'(mif.done), 32'd0);
        chk({nm, " lo rdata"}, 32'(mif.read_data), 32'(last_rd));
        tick();
        @(negedge clk);
        chk({nm, " done"}, 32'(mif.done), 32'd1);
        chk({nm, " error"}, 32'(mif.error), 32'd0);
        chk({nm, " done ready"}, 32'(mif.ready), 32'd1);
        chk({nm, " rdata"}, 32'(mif.read_data), 32'(exp_rd));
        chk({nm, " idle we"}, 32'(mif.mem_write), 32'd0);
        if (wr) begin
            chk({nm, " mem hi"}, 32'(mem[a]), 32'(d[15:8]));
            chk({nm, " mem lo"}, 32'(mem[a1]), 32'(d[7:0]));
        end
        last_rd = exp_rd;
        tick();
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(mif.done), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hAB;
        mem[16'h0011] = 8'hCD;
        mem[16'h0031] = 8'h11;
        mem[16'hFFFF] = 8'h77;
        mem[16'h0000] = 8'h88;

        tbl[0] = '{1'b0, 16'h0010, 16'h0000, 16'hABCD};
        tbl[1] = '{1'b1, 16'h0020, 16'h1234, 16'hABCD};
        tbl[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1234};
        tbl[3] = '{1'b1, 16'h0100, 16'h5A5A, 16'h1234};
        tbl[4] = '{1'b0, 16'h0100, 16'h0000, 16'h5A5A};
        tbl[5] = '{1'b1, 16'h0200, 16'h00FF, 16'h5A5A};

        mif.req        = 1'b0;
        mif.write      = 1'b0;
        mif.address    = '0;
        mif.write_data = '0;
        rst            = 1'b1;
        last_rd        = 16'h0000;

        tick();
        tick();
        @(negedge clk);
        chk("rst ready", 32'(mif.ready), 32'd0);
        chk("rst done", 32'(mif.done), 32'd0);
        chk("rst error", 32'(mif.error), 32'd0);
        chk("rst rdata", 32'(mif.read_data), 32'd0);
        chk("rst we", 32'(mif.mem_write), 32'd0);
        chk("rst re", 32'(mif.mem_read), 32'd0);
        chk("rst addr", 32'(mif.mem_address), 32'd0);
        chk("rst byte", 32'(mif.mem_write_byte), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", 32'(mif.ready), 32'd1);
        tick();

        for (int i = 0; i < 6; i++) begin
            txn(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp_rd,
                $sformatf("vec%0d", i));
        end

        // Back-to-back: Req held, second request accepted at completion edge.
        mif.req        = 1'b1;
        mif.write      = 1'b1;
        mif.address    = 16'h0040;
        mif.write_data = 16'hCAFE;
        @(negedge clk);
        chk("b2b ready0", 32'(mif.ready), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b hi we", 32'(mif.mem_write), 32'd1);
        chk("b2b busy ready", 32'(mif.ready), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b lo addr", 32'(mif.mem_address), 32'h41);
        chk("b2b lo done", 32'(mif.done), 32'd0);
        tick();
        mif.write = 1'b0;
        @(negedge clk);
        chk("b2b done1", 32'(mif.done), 32'd1);
        chk("b2b done1 ready", 32'(mif.ready), 32'd1);
        tick();
        @(negedge clk);
        mif.req = 1'b0;
        chk("b2b 2nd hi re", 32'(mif.mem_read), 32'd1);
        chk("b2b 2nd hi addr", 32'(mif.mem_address), 32'h40);
        chk("b2b 2nd hi done", 32'(mif.done), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b 2nd lo addr", 32'(mif.mem_address), 32'h41);
        chk("b2b 2nd lo done", 32'(mif.done), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b done2", 32'(mif.done), 32'd1);
        chk("b2b rdata", 32'(mif.read_data), 32'hCAFE);
        tick();
        @(negedge clk);
        chk("b2b done2 pulse", 32'(mif.done), 32'd0);
        tick();

        // Reset during the HI cycle of a store.
        mif.req        = 1'b1;
        mif.write      = 1'b1;
        mif.address    = 16'h0030;
        mif.write_data = 16'hBEEF;
        @(negedge clk);
        tick();
        mif.req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("rhi we", 32'(mif.mem_write), 32'd1);
        chk("rhi ready", 32'(mif.ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rhi done", 32'(mif.done), 32'd0);
        chk("rhi ready after", 32'(mif.ready), 32'd1);
        chk("rhi idle we", 32'(mif.mem_write), 32'd0);
        chk("rhi mem30", 32'(mem[16'h0030]), 32'hBE);
        chk("rhi mem31", 32'(mem[16'h0031]), 32'h11);
        chk("rhi rdata", 32'(mif.read_data), 32'd0);
        tick();
        @(negedge clk);
        chk("rhi no late done", 32'(mif.done), 32'd0);
        tick();
        last_rd = 16'h0000;
        txn(1'b0, 16'h0030, 16'h0000, 16'hBE11, "ld30");

`ifdef ALIGN_CHECK_EN
        mif.req     = 1'b1;
        mif.write   = 1'b0;
        mif.address = 16'h0041;
        @(negedge clk);
        tick();
        mif.req = 1'b0;
        @(negedge clk);
        chk("mis done", 32'(mif.done), 32'd1);
        chk("mis error", 32'(mif.error), 32'd1);
        chk("mis re", 32'(mif.mem_read), 32'd0);
        chk("mis we", 32'(mif.mem_write), 32'd0);
        chk("mis rdata", 32'(mif.read_data), 32'hBE11);
        chk("mis ready", 32'(mif.ready), 32'd1);
        tick();
        @(negedge clk);
        chk("mis done pulse", 32'(mif.done), 32'd0);
        chk("mis error pulse", 32'(mif.error), 32'd0);
        tick();
`else
        txn(1'b0, 16'hFFFF, 16'h0000, 16'h7788, "wrap");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
